uart_rx_fifo: RTL and testbench



---
 rtl/uart_rx_fifo.sv | 174 +++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: 8N1 UART receiver feeding a circular receive FIFO.
// Bytes are read one at a time through a single-register request/response
// port. Status bits carry overrun and framing errors. A level interrupt
// flags each byte that is accepted into the FIFO.
module uart_rx_fifo #(
    parameter int CLK_FREQ   = 25_000_000,
    parameter int BAUD_RATE  = 57600,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        rx_i,
    input  logic        read_request_i,
    output logic        read_response_o,
    output logic [31:0] read_data_o,
    output logic        irq_o,
    input  logic        irq_ack_i
);
    localparam int BIT  = CLK_FREQ / BAUD_RATE;
    localparam int HALF = BIT / 2;
    localparam int CW   = $clog2(BIT);
    localparam int AW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_d;
    logic          rx_meta, rx_sync, rx_prev;
    logic [CW-1:0] cnt;
    logic [2:0]    idx;
    logic [7:0]    shift;
    logic          fall, half_hit, bit_hit;
    logic          push, frame_err;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [AW:0]   count;
    logic          full, empty, rd_start, pop, push_ok, ovr_set;
    logic          ovr_flag, frm_flag;

    // Two-flop synchroniser for rx_i, plus one more stage for edge detection.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx_i;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    assign fall     = rx_prev & ~rx_sync;
    assign half_hit = (cnt == CW'(HALF - 1));
    assign bit_hit  = (cnt == CW'(BIT - 1));

    // FSM state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_d;
    end

    // FSM next state: a start bit that is high again at mid-bit is treated as a glitch.
    always_comb begin
        state_d = state;
        case (state)
            IDLE:  if (fall) state_d = START;
            START: if (half_hit) state_d = rx_sync ? IDLE : DATA;
            DATA:  if (bit_hit && idx == 3'd7) state_d = STOP;
            STOP:  if (bit_hit) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM outputs: stop-bit decision.
    always_comb begin
        push      = 1'b0;
        frame_err = 1'b0;
        if (state == STOP && bit_hit) begin
            push      = rx_sync;
            frame_err = ~rx_sync;
        end
    end

    // Bit-timing counter, bit index and LSB-first shift register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt   <= '0;
            idx   <= '0;
            shift <= '0;
        end else begin
            case (state)
                IDLE: cnt <= '0;
                START: begin
                    cnt <= half_hit ? '0 : cnt + 1'b1;
                    idx <= '0;
                end
                DATA: begin
                    if (bit_hit) begin
                        cnt        <= '0;
                        shift[idx] <= rx_sync;
                        idx        <= idx + 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                STOP: cnt <= bit_hit ? '0 : cnt + 1'b1;
                default: cnt <= '0;
            endcase
        end
    end

    assign full     = (count == (AW+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign rd_start = read_request_i & ~read_response_o;
    assign pop      = rd_start & ~empty;
    // A pop in the same cycle frees the slot, so a push into a full FIFO is still accepted.
    assign push_ok  = push & (~full | pop);
    assign ovr_set  = push & full & ~pop;

    // FIFO storage; no reset needed since count gates visibility.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem[wr_ptr] <= shift;
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop)     rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Error flags: any read clears them, a simultaneous new event wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ovr_flag <= 1'b0;
            frm_flag <= 1'b0;
        end else begin
            ovr_flag <= ovr_set   | (ovr_flag & ~rd_start);
            frm_flag <= frame_err | (frm_flag & ~rd_start);
        end
    end

    // Read response: one-cycle ack, data captured with it and held afterwards.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            read_response_o <= 1'b0;
            read_data_o     <= '0;
        end else begin
            read_response_o <= rd_start;
            if (rd_start)
                read_data_o <= {21'b0, frm_flag, ovr_flag, ~empty,
                                empty ? 8'h00 : mem[rd_ptr]};
        end
    end

    // Interrupt: set by an accepted byte, cleared by ack; set wins.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)        irq_o <= 1'b0;
        else if (push_ok)   irq_o <= 1'b1;
        else if (irq_ack_i) irq_o <= 1'b0;
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo with a short bit period to keep runs small.
module tb_uart_rx_fifo;
    localparam int CLK_FREQ = 25_000_000;
    localparam int BAUD     = 250_000;
    localparam int BIT      = CLK_FREQ / BAUD;   // 100
    localparam int HALF     = BIT / 2;           // 50
    localparam int DEPTH    = 16;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        rx = 1'b1;
    logic        req = 1'b0;
    logic        ack = 1'b0;
    logic        resp;
    logic [31:0] data;
    logic        irq;
    int          n_cmp = 0;
    int          n_bad = 0;

    always #5 clk = ~clk;

    uart_rx_fifo #(.CLK_FREQ(CLK_FREQ), .BAUD_RATE(BAUD), .FIFO_DEPTH(DEPTH)) dut (
        .clk_i(clk), .rst_ni(rst_n), .rx_i(rx),
        .read_request_i(req), .read_response_o(resp), .read_data_o(data),
        .irq_o(irq), .irq_ack_i(ack)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Call right after a rising edge; returns right after a rising edge.
    task automatic send_byte(input logic [7:0] b, input logic stop);
        #1 rx = 1'b0;
        repeat (BIT) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            #1 rx = b[i];
            repeat (BIT) @(posedge clk);
        end
        #1 rx = stop;
        repeat (BIT) @(posedge clk);
        #1 rx = 1'b1;
        repeat (4) @(posedge clk);
    endtask

    task automatic do_read(output logic [31:0] d);
        logic got;
        got = 1'b0;
        d   = 32'hDEAD_BEEF;
        @(posedge clk);
        #1 req = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk);
            #1;
            if (resp) begin
                d   = data;
                got = 1'b1;
                break;
            end
        end
        req = 1'b0;
        chk("rd_ack", {31'b0, got}, 32'd1);
    endtask

    task automatic read_chk(input string tag, input logic [31:0] exp);
        logic [31:0] d;
        do_read(d);
        chk(tag, d, exp);
    endtask

    task automatic pulse_ack();
        @(posedge clk);
        #1 ack = 1'b1;
        @(posedge clk);
        #1 ack = 1'b0;
    endtask

    initial begin
        logic [31:0] d;
        logic [31:0] exp_d [6];
        logic        exp_r [6];

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_resp", {31'b0, resp}, 32'd0);
        chk("rst_data", data, 32'd0);
        chk("rst_irq", {31'b0, irq}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);

        // Single byte 0xA5
        send_byte(8'hA5, 1'b1);
        chk("a5_irq", {31'b0, irq}, 32'd1);
        read_chk("a5_rd", 32'h0000_01A5);
        read_chk("a5_rd2", 32'h0000_0000);
        pulse_ack();
        chk("a5_ack", {31'b0, irq}, 32'd0);

        // 17 bytes into a 16-deep FIFO: last is dropped with overrun
        @(posedge clk);
        for (int b = 0; b < 17; b++) send_byte(8'(b), 1'b1);
        read_chk("ovr_rd0", 32'h0000_0300);
        for (int i = 1; i < 16; i++) read_chk("ovr_rd", 32'h100 | 32'(i));
        read_chk("ovr_rd16", 32'h0000_0000);
        pulse_ack();

        // Full FIFO, pop coincides with stop-bit push of 0x55
        @(posedge clk);
        for (int b = 0; b < 16; b++) send_byte(8'h80 + 8'(b), 1'b1);
        @(posedge clk);
        fork
            send_byte(8'h55, 1'b1);
            begin
                repeat (1 + HALF + 9*BIT) @(posedge clk);
                do_read(d);
            end
        join
        chk("coin_rd0", d, 32'h0000_0180);
        for (int i = 1; i < 16; i++) read_chk("coin_rd", 32'h180 | 32'(i));
        read_chk("coin_55", 32'h0000_0155);
        read_chk("coin_empty", 32'h0000_0000);
        pulse_ack();
        chk("coin_ack", {31'b0, irq}, 32'd0);

        // Framing error on 0x3C
        @(posedge clk);
        send_byte(8'h3C, 1'b0);
        chk("frm_irq", {31'b0, irq}, 32'd0);
        read_chk("frm_rd", 32'h0000_0400);
        read_chk("frm_rd2", 32'h0000_0000);

        // Short low glitch shorter than half a bit
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (HALF - 20) @(posedge clk);
        #1 rx = 1'b1;
        repeat (2*BIT) @(posedge clk);
        chk("glitch_irq", {31'b0, irq}, 32'd0);
        read_chk("glitch_rd", 32'h0000_0000);

        // Request held high for 6 cycles with 0x11, 0x22 queued
        @(posedge clk);
        send_byte(8'h11, 1'b1);
        send_byte(8'h22, 1'b1);
        exp_r = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
        exp_d = '{32'h111, 32'h0, 32'h122, 32'h0, 32'h000, 32'h0};
        @(posedge clk);
        #1 req = 1'b1;
        for (int s = 0; s < 6; s++) begin
            @(posedge clk);
            #1;
            chk("hold_resp", {31'b0, resp}, {31'b0, exp_r[s]});
            if (exp_r[s]) chk("hold_data", data, exp_d[s]);
            if (s == 5) req = 1'b0;
        end
        chk("hold_irq", {31'b0, irq}, 32'd1);
        pulse_ack();
        chk("hold_ack", {31'b0, irq}, 32'd0);

        // Reset in the middle of a frame, with a byte already buffered
        @(posedge clk);
        send_byte(8'h77, 1'b1);
        #1 rx = 1'b0;
        repeat (3*BIT) @(posedge clk);
        #1 rst_n = 1'b0;
        @(posedge clk);
        #1;
        chk("mrst_irq", {31'b0, irq}, 32'd0);
        chk("mrst_resp", {31'b0, resp}, 32'd0);
        rx = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        repeat (2*BIT) @(posedge clk);
        read_chk("mrst_rd", 32'h0000_0000);
        chk("mrst_irq2", {31'b0, irq}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
